conv_32b_8b: RTL and testbench

- Serializer: takes 32-bit parallel words and emits them as four 8-bit bytes, MSB byte first, one byte per clk_4f cycle.
- It is the transmit-side counterpart of the 8b-to-32b collector in the 8b_32b path.
- A one-word pending slot lets back-to-back words stream with no idle cycle between them.

---
 rtl/conv_32b_8b.sv | 128 ++++++++++++
 tb/tb_conv_32b_8b.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_32b_8b.sv
// 32-bit to 8-bit serializer: MSB byte first, one byte per clk_4f, with a one-word pending slot.
// Optional byte_idx/sof outputs are enabled with `define CONV_32B_8B_BYTE_IDX_EN.
module conv_32b_8b #(
    parameter logic [7:0] IDLE_DATA = 8'h00
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [7:0]  data_out,
`ifdef CONV_32B_8B_BYTE_IDX_EN
    output logic [1:0]  byte_idx,
    output logic        sof,
`endif
    output logic        valid_out
);

    logic [31:0] act_q, act_d;
    logic        act_v_q, act_v_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        sof_q, sof_d;

    logic busy;
    logic accept;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // ready_in depends only on state, never on valid_in
    assign ready_in = !pend_v_q;
    assign accept   = valid_in && !pend_v_q;
    assign busy     = act_v_q && (cnt_q != 2'd3);

    always_comb begin
        act_d       = act_q;
        act_v_d     = act_v_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;

        if (busy) begin
            cnt_d       = cnt_q + 2'd1;
            data_out_d  = byte_sel(act_q, cnt_q + 2'd1);
            valid_out_d = 1'b1;
            if (accept) begin
                pend_d   = data_in;
                pend_v_d = 1'b1;
            end
        end else if (pend_v_q) begin
            // pending word beats a simultaneous input; ready_in is low here anyway
            act_d       = pend_q;
            act_v_d     = 1'b1;
            pend_v_d    = 1'b0;
            cnt_d       = 2'd0;
            data_out_d  = pend_q[31:24];
            valid_out_d = 1'b1;
        end else if (valid_in) begin
            act_d       = data_in;
            act_v_d     = 1'b1;
            cnt_d       = 2'd0;
            data_out_d  = data_in[31:24];
            valid_out_d = 1'b1;
        end else begin
            act_v_d     = 1'b0;
            cnt_d       = 2'd0;
            data_out_d  = IDLE_DATA;
            valid_out_d = 1'b0;
        end
    end

    always_comb begin
        byte_idx_d = valid_out_d ? cnt_d : 2'd0;
        sof_d      = valid_out_d && (cnt_d == 2'd0);
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            act_q       <= 32'd0;
            act_v_q     <= 1'b0;
            pend_q      <= 32'd0;
            pend_v_q    <= 1'b0;
            cnt_q       <= 2'd0;
            data_out_q  <= IDLE_DATA;
            valid_out_q <= 1'b0;
            byte_idx_q  <= 2'd0;
            sof_q       <= 1'b0;
        end else begin
            act_q       <= act_d;
            act_v_q     <= act_v_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            byte_idx_q  <= byte_idx_d;
            sof_q       <= sof_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

`ifdef CONV_32B_8B_BYTE_IDX_EN
    assign byte_idx = byte_idx_q;
    assign sof      = sof_q;
`else
    // index/sof flops stay unobserved when the optional ports are absent
    logic unused_idx;
    assign unused_idx = ^{byte_idx_q, sof_q};
`endif

endmodule

// File: tb/tb_conv_32b_8b.sv
// Scoreboard bench for conv_32b_8b: driver pushes expected bytes on handshake, monitor pops on valid_out.
module tb_conv_32b_8b;

    logic        clk_4f = 1'b0;
    logic        reset_L = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        valid_out;
`ifdef CONV_32B_8B_BYTE_IDX_EN
    logic [1:0]  byte_idx;
    logic        sof;
`endif

    always #5 clk_4f = ~clk_4f;

    conv_32b_8b dut (
        .clk_4f   (clk_4f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (data_out),
`ifdef CONV_32B_8B_BYTE_IDX_EN
        .byte_idx (byte_idx),
        .sof      (sof),
`endif
        .valid_out(valid_out)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_len = 0;
    int   gap_len = 0;
    int   last_run = 0;
    int   last_gap = -1;
    bit   seen_burst = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: one comparison per cycle, popping an expected byte whenever valid_out is high
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_4f);
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %h required no byte", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {24'd0, data_out}, {24'd0, e.b});
                    $display("[TB] byte %h idx %0d", data_out, e.idx);
`ifdef CONV_32B_8B_BYTE_IDX_EN
                    check("byte_idx", {30'd0, byte_idx}, {30'd0, e.idx});
                    check("sof", {31'd0, sof}, {31'd0, (e.idx == 2'd0)});
`endif
                end
                if (prev_valid !== 1'b1 && seen_burst) last_gap = gap_len;
                run_len++;
            end else begin
                check("idle_data", {24'd0, data_out}, 32'h00);
                check("idle_valid", {31'd0, valid_out}, 32'd0);
`ifdef CONV_32B_8B_BYTE_IDX_EN
                check("idle_byte_idx", {30'd0, byte_idx}, 32'd0);
                check("idle_sof", {31'd0, sof}, 32'd0);
`endif
                if (prev_valid === 1'b1) begin
                    last_run   = run_len;
                    run_len    = 0;
                    seen_burst = 1'b1;
                    gap_len    = 0;
                end
                gap_len++;
            end
            prev_valid = valid_out;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_4f);
            @(negedge clk_4f);
        end
    endtask

    // Present a word, wait (bounded) for ready_in, push its four bytes at the accepting edge
    task automatic send_word(input logic [31:0] w, output int waits);
        waits    = 0;
        data_in  = w;
        valid_in = 1'b1;
        while (ready_in !== 1'b1 && waits < 20) begin
            @(posedge clk_4f);
            @(negedge clk_4f);
            waits++;
        end
        if (ready_in !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready_in=%b required 1", ready_in);
        end else begin
            @(posedge clk_4f);
            exp_q.push_back({w[31:24], 2'd0});
            exp_q.push_back({w[23:16], 2'd1});
            exp_q.push_back({w[15:8],  2'd2});
            exp_q.push_back({w[7:0],   2'd3});
            @(negedge clk_4f);
        end
        valid_in = 1'b0;
        data_in  = 32'd0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || valid_out === 1'b1) && t < 100) begin
            @(negedge clk_4f);
            t++;
        end
        if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes left required 0", exp_q.size());
        end
        idle(2);
    endtask

    initial begin
        int w;
        repeat (2) @(negedge clk_4f);
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_data", {24'd0, data_out}, 32'h00);
        check("reset_ready", {31'd0, ready_in}, 32'd1);
        reset_L = 1'b1;
        idle(2);

        // single word from idle
        send_word(32'hDEADBEEF, w);
        drain();
        check("single_run", last_run, 4);

        // back-to-back, second word at the cnt=3 edge
        send_word(32'h01020304, w);
        idle(3);
        send_word(32'h05060708, w);
        drain();
        check("stream_run", last_run, 8);

        // pending slot fills, ready_in drops until it drains
        send_word(32'h11223344, w);
        send_word(32'h55667788, w);
        check("pend_ready_low", {31'd0, ready_in}, 32'd0);
        send_word(32'h99AABBCC, w);
        check("pend_wait_cycles", w, 3);
        drain();
        check("pend_run", last_run, 12);

        // three idle cycles between bursts
        send_word(32'hCAFEF00D, w);
        idle(6);
        send_word(32'h12345678, w);
        drain();
        check("gap_len", last_gap, 3);
        check("gap_run", last_run, 4);

        // reset after byte B2; no further bytes may appear
        send_word(32'hA1B2C3D4, w);
        @(posedge clk_4f);
        @(negedge clk_4f);
        #2;
        reset_L = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_valid", {31'd0, valid_out}, 32'd0);
        check("midreset_data", {24'd0, data_out}, 32'h00);
        check("midreset_ready", {31'd0, ready_in}, 32'd1);
        @(negedge clk_4f);
        @(negedge clk_4f);
        reset_L = 1'b1;
        idle(6);
        check("midreset_run", last_run, 2);

`ifdef CONV_32B_8B_BYTE_IDX_EN
        send_word(32'hA0A1A2A3, w);
        drain();
        check("idx_run", last_run, 4);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
